// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 2-to-4 decoder: walks the enabled select slots in
// ascending order with a programmable dwell and optional blanking gap.
module decoder_scan_ctrl #(
  parameter int DWELL = 8,
  parameter int BLANK = 1,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] mask,
  output logic       s1,
  output logic       s0,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam bit            HAS_BLANK  = (BLANK > 0);

  state_t        r_state, w_nxt_state;
  logic [1:0]    r_slot, w_nxt_slot;
  logic [1:0]    r_pend, w_nxt_pend;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [3:0]    r_mask_q, w_nxt_mask;
  logic          r_mode_q, w_nxt_mode;
  logic          w_nxt_done;
  logic          r_en, r_busy, r_done;
  logic [1:0]    r_sel;
  logic [2:0]    w_lowest;
  logic [2:0]    w_next;

  // Both helpers return {found, index}.
  function automatic logic [2:0] lowest_set(input logic [3:0] m);
    lowest_set = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_set = {1'b1, 2'(i)};
  endfunction

  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] s);
    next_above = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(s))) next_above = {1'b1, 2'(i)};
  endfunction

  assign w_lowest = lowest_set(mask);
  assign w_next   = next_above(r_mask_q, r_slot);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_slot  = r_slot;
    w_nxt_pend  = r_pend;
    w_nxt_cnt   = r_cnt;
    w_nxt_mask  = r_mask_q;
    w_nxt_mode  = r_mode_q;
    w_nxt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop && (mask != 4'b0000)) begin
          w_nxt_state = ST_SHOW;
          w_nxt_mask  = mask;
          w_nxt_mode  = mode;
          w_nxt_slot  = w_lowest[1:0];
          w_nxt_cnt   = '0;
        end
      end
      ST_SHOW: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_slot  = 2'd0;
          w_nxt_cnt   = '0;
        end else if (r_cnt == DWELL_LAST) begin
          w_nxt_cnt = '0;
          if (w_next[2]) begin
            if (HAS_BLANK) begin
              w_nxt_state = ST_BLANK;
              w_nxt_pend  = w_next[1:0];
            end else begin
              w_nxt_slot = w_next[1:0];
            end
          end else begin
            // End of sweep: continuous mode re-reads the live mask here.
            w_nxt_done = 1'b1;
            if (r_mode_q) w_nxt_mask = mask;
            if (!r_mode_q || (mask == 4'b0000)) begin
              w_nxt_state = ST_IDLE;
              w_nxt_slot  = 2'd0;
            end else if (HAS_BLANK) begin
              w_nxt_state = ST_BLANK;
              w_nxt_pend  = w_lowest[1:0];
            end else begin
              w_nxt_slot = w_lowest[1:0];
            end
          end
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      ST_BLANK: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_slot  = 2'd0;
          w_nxt_cnt   = '0;
        end else if (r_cnt == BLANK_LAST) begin
          w_nxt_state = ST_SHOW;
          w_nxt_slot  = r_pend;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_slot  = 2'd0;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_slot   <= 2'd0;
      r_pend   <= 2'd0;
      r_cnt    <= '0;
      r_mask_q <= 4'b0000;
      r_mode_q <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sel    <= 2'd0;
    end else begin
      r_state  <= w_nxt_state;
      r_slot   <= w_nxt_slot;
      r_pend   <= w_nxt_pend;
      r_cnt    <= w_nxt_cnt;
      r_mask_q <= w_nxt_mask;
      r_mode_q <= w_nxt_mode;
      r_en     <= (w_nxt_state == ST_SHOW);
      r_busy   <= (w_nxt_state != ST_IDLE);
      r_done   <= w_nxt_done;
      r_sel    <= w_nxt_slot;
    end
  end

  assign s1        = r_sel[1];
  assign s0        = r_sel[0];
  assign en        = r_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: three parameterisations share one stimulus
// stream and are checked each cycle against a per-sweep schedule model.
module tb_decoder_scan_ctrl;

  localparam int DW0 = 2, BL0 = 1;
  localparam int DW1 = 1, BL1 = 0;
  localparam int DW2 = 3, BL2 = 2;

  logic       clk;
  logic       rst, start, stop, mode;
  logic [3:0] mask;
  logic [2:0] w_s1, w_s0, w_en, w_busy, w_done;
  logic [1:0] w_dbg0, w_dbg1, w_dbg2;

  decoder_scan_ctrl #(.DWELL(DW0), .BLANK(BL0), .CW(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .s1(w_s1[0]), .s0(w_s0[0]), .en(w_en[0]), .busy(w_busy[0]), .done(w_done[0]),
    .dbg_state(w_dbg0));
  decoder_scan_ctrl #(.DWELL(DW1), .BLANK(BL1), .CW(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .s1(w_s1[1]), .s0(w_s0[1]), .en(w_en[1]), .busy(w_busy[1]), .done(w_done[1]),
    .dbg_state(w_dbg1));
  decoder_scan_ctrl #(.DWELL(DW2), .BLANK(BL2), .CW(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .s1(w_s1[2]), .s0(w_s0[2]), .en(w_en[2]), .busy(w_busy[2]), .done(w_done[2]),
    .dbg_state(w_dbg2));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Record layout: {done, busy, en, sel[1:0]}.
  logic [4:0] exp_q[3][$];
  logic [4:0] cur[3];
  bit         cont[3];
  int         n_checks = 0;
  int         n_fail   = 0;
  string      phase    = "reset";

  function automatic int dw_of(int k);
    case (k)
      0:       dw_of = DW0;
      1:       dw_of = DW1;
      default: dw_of = DW2;
    endcase
  endfunction

  function automatic int bl_of(int k);
    case (k)
      0:       bl_of = BL0;
      1:       bl_of = BL1;
      default: bl_of = BL2;
    endcase
  endfunction

  // Queue every cycle of one sweep over the set bits of m, ascending.
  task automatic build_sweep(int k, logic [3:0] m, logic [1:0] prev, bit lead_blank);
    logic [1:0] last;
    bit         first;
    last  = prev;
    first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (!first || lead_blank)
          for (int b = 0; b < bl_of(k); b++) exp_q[k].push_back({1'b0, 1'b1, 1'b0, last});
        for (int d = 0; d < dw_of(k); d++) exp_q[k].push_back({1'b0, 1'b1, 1'b1, 2'(i)});
        last  = 2'(i);
        first = 1'b0;
      end
    end
  endtask

  task automatic model_step(int k);
    if (rst) begin
      exp_q[k].delete();
      cur[k] = 5'b0;
    end else if (cur[k][3]) begin
      if (stop) begin
        exp_q[k].delete();
        cur[k] = 5'b0;
      end else if (exp_q[k].size() > 0) begin
        cur[k] = exp_q[k].pop_front();
      end else if (!cont[k] || (mask == 4'b0000)) begin
        cur[k] = 5'b10000;
      end else begin
        build_sweep(k, mask, cur[k][1:0], 1'b1);
        cur[k]    = exp_q[k].pop_front();
        cur[k][4] = 1'b1;
      end
    end else if (start && !stop && (mask != 4'b0000)) begin
      cont[k] = mode;
      build_sweep(k, mask, 2'd0, 1'b0);
      cur[k] = exp_q[k].pop_front();
    end else begin
      cur[k] = 5'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cur[k]  = 5'b0;
      cont[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  // ---------------- scoreboard ----------------
  task automatic check_all();
    logic [4:0] obs;
    for (int k = 0; k < 3; k++) begin
      obs = {w_done[k], w_busy[k], w_en[k], w_s1[k], w_s0[k]};
      n_checks++;
      assert (obs === cur[k]) else begin
        n_fail++;
        $error("FAIL %s inst%0d observed={done,busy,en,sel}=%b expected=%b", phase, k, obs, cur[k]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(logic [3:0] m, logic md);
    mask  = m;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 4'b0000;
    run(2);
    rst = 1'b0;
    run(2);

    // Single masked sweep with a direct check on the inst0 done cycle.
    phase = "single_sweep";
    pulse_start(4'b1011, 1'b0);
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (c == 9) begin
        n_checks++;
        assert ({w_done[0], w_busy[0], w_en[0]} === 3'b100) else begin
          n_fail++;
          $error("FAIL sweep_done_c9 observed={done,busy,en}=%b expected=100",
                 {w_done[0], w_busy[0], w_en[0]});
        end
      end
    end

    phase = "reset_mid_show";
    pulse_start(4'b1111, 1'b0);
    run(1);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(10);

    phase = "continuous";
    pulse_start(4'b1111, 1'b1);
    run(16);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run(2);

    phase = "stop_in_blank";
    pulse_start(4'b0011, 1'b0);
    run(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run(4);

    phase = "start_mask0";
    pulse_start(4'b0000, 1'b1);
    run(3);

    phase = "start_and_stop";
    stop = 1'b1;
    pulse_start(4'b0110, 1'b0);
    stop = 1'b0;
    run(3);

    phase = "start_while_busy";
    pulse_start(4'b1101, 1'b0);
    run(3);
    pulse_start(4'b0010, 1'b1);
    run(20);

    phase = "continuous_remask";
    pulse_start(4'b0001, 1'b1);
    run(2);
    mask = 4'b0100;
    run(20);
    mask = 4'b0000;
    run(12);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      mode  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
